// File: rtl/mem_slave_pkg.sv
// mem_slave_pkg: shared state type and read-latency limits for mem_slave_pipe
package mem_slave_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: LAT-deep valid/data delay line, flushed by synchronous rst
// ports: v_i/d_i enter at stage 0, v_o/d_o leave after LAT edges; d_o holds while no valid arrives
module mem_rd_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  input  logic [W-1:0] d_i,
  output logic         v_o,
  output logic [W-1:0] d_o
);
  logic [LAT-1:0] v_q, v_d;
  logic [W-1:0]   d_q [LAT];
  logic [W-1:0]   d_w [LAT];
  always_comb begin
    v_d = (v_q << 1) | LAT'(v_i);
    d_w[0] = d_i;
    for (int i = 1; i < LAT; i++) d_w[i] = d_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < LAT - 1; i++) d_q[i] <= d_w[i];
      if (v_d[LAT-1]) d_q[LAT-1] <= d_w[LAT-1];
    end
  end
  assign v_o = v_q[LAT-1];
  assign d_o = d_q[LAT-1];
endmodule

// File: rtl/mem_slave_pipe.sv
// mem_slave_pipe: self-clearing single-port memory slave with pipelined fixed-latency reads
// ports: req/write/address/data_in request, ready accept, data_out/rd_valid read return
// option: MEM_SLAVE_PARITY_EN adds per-word even parity and output parity_err
module mem_slave_pipe
  import mem_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
`ifdef MEM_SLAVE_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LAT = RD_LAT < RD_LAT_MIN ? RD_LAT_MIN : RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT;
`ifdef MEM_SLAVE_PARITY_EN
  localparam int unsigned PW = DATA_W + 1;
`else
  localparam int unsigned PW = DATA_W;
`endif
  state_e            state_q;
  logic [ADDR_W-1:0] clr_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              acc;
  logic [PW-1:0]     pd_in, pd_out;
  assign acc = req & ready_q & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      clr_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      clr_q <= clr_q + 1'b1;
      if (&clr_q) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem_q[clr_q] <= '0;
    else if (acc && write) mem_q[address] <= data_in;
  end
`ifdef MEM_SLAVE_PARITY_EN
  logic par_q [DEPTH];
  always_ff @(posedge clk) begin
    if (state_q == INIT) par_q[clr_q] <= 1'b0;
    else if (acc && write) par_q[address] <= ^data_in;
  end
  assign pd_in      = {par_q[address] ^ (^mem_q[address]), mem_q[address]};
  assign parity_err = rd_valid & pd_out[DATA_W];
`else
  assign pd_in = mem_q[address];
`endif
  mem_rd_pipe #(.LAT(LAT), .W(PW)) u_pipe (
    .clk(clk),
    .rst(rst),
    .v_i(acc & ~write),
    .d_i(pd_in),
    .v_o(rd_valid),
    .d_o(pd_out)
  );
  assign ready    = ready_q;
  assign data_out = pd_out[DATA_W-1:0];
endmodule

// File: doc/mem_slave_pipe.md
MEM_SLAVE_PIPE -- requirements
Module: mem_slave_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter RD_LAT, default 2, legal 1..4, meaning read latency in cycles.
REQ-004 Port clk: input, 1 bit, sole clock; all logic on posedge clk.
REQ-005 Port rst: input, 1 bit, reset; one clock, reset is synchronous and active-high.
REQ-006 Port req: input, 1 bit, request valid.
REQ-007 Port write: input, 1 bit, 1 = write, 0 = read; sampled with req.
REQ-008 Port address: input, ADDR_W bits, word address.
REQ-009 Port data_in: input, DATA_W bits, write data.
REQ-010 Port ready: output, 1 bit, request accepted on any edge where req && ready.
REQ-011 Port data_out: output, DATA_W bits, read data.
REQ-012 Port rd_valid: output, 1 bit, one-cycle pulse qualifying data_out.

Function
REQ-013 FSM SHALL have two states: INIT (clears memory) and RUN (serves requests).
REQ-014 INIT SHALL write 0 to one word per cycle, addresses 0..DEPTH-1 ascending, then enter RUN; INIT takes exactly DEPTH cycles.
REQ-015 ready SHALL be 0 in INIT and 1 in RUN; requests while ready = 0 are ignored with no side effects.
REQ-016 Accepted write SHALL update mem[address] on the accepting edge; no rd_valid is produced.
REQ-017 Accepted read SHALL drive data_out = mem[address] with rd_valid = 1 exactly RD_LAT cycles after the accepting edge.
REQ-018 Reads SHALL be fully pipelined: one accepted request per cycle, back-to-back reads give back-to-back rd_valid pulses in order.
REQ-019 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-020 data_out SHALL hold its last read value while rd_valid = 0.
REQ-021 Address wrap: addresses are modulo DEPTH; no out-of-range condition exists.

Reset
REQ-022 On rst = 1 at a clock edge: state = INIT, clear pointer = 0, ready = 0, rd_valid = 0, data_out = 0, all pending read-pipeline stages discarded.
REQ-023 rst asserted mid-INIT SHALL restart clearing from address 0; rst mid-read SHALL suppress that read's rd_valid.

Configuration
REQ-024 Macro MEM_SLAVE_PARITY_EN SHALL, when defined, store one even-parity bit per word (computed from data_in on write, 0 during INIT) and add output parity_err (1 bit, reset 0), asserted with rd_valid when stored parity mismatches stored data.
REQ-025 Without MEM_SLAVE_PARITY_EN, no parity storage exists and port parity_err is absent.

Structure
REQ-026 Package mem_slave_pkg SHALL hold typedef state_e {INIT, RUN} and constants RD_LAT_MIN = 1, RD_LAT_MAX = 4.
REQ-027 Sub-module mem_rd_pipe (RD_LAT-deep valid/data delay line with synchronous flush) SHALL implement the read latency.

Verification
REQ-028 Reset then count: rst 1 cycle, ADDR_W = 8 -> ready rises exactly 256 cycles after rst drop; reading address 0x7F returns 0x0000.
REQ-029 Write 0xBEEF to 0x10, read 0x10 next cycle, RD_LAT = 2 -> rd_valid 2 cycles after read accept, data_out = 0xBEEF.
REQ-030 Reads of 0x01,0x02,0x03 on consecutive cycles after writing 0x1111,0x2222,0x3333 -> three consecutive rd_valid pulses, data in that order.
REQ-031 req held during INIT with write = 1, data 0xFFFF, address 0x05 -> after INIT, read 0x05 returns 0x0000.
REQ-032 rst asserted one cycle after a read accept -> no rd_valid; data_out = 0; INIT restarts at address 0.
REQ-033 With MEM_SLAVE_PARITY_EN, force a stored data bit flip at 0x20 then read -> parity_err = 1 with rd_valid; clean read -> parity_err = 0.
